// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART blocks: the receiver, the RX byte FIFO and the
// TX byte FIFO all use the same data width and default buffer depth.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Width of one UART character as seen by the buffers.
   localparam int UART_DATA_W       = 8;

   // Default number of entries in the receive FIFO (power of two).
   localparam int UART_RXFIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x W register array with one synchronous write port and one
// asynchronous (combinational) read port. Used as the storage of the RX and TX
// byte FIFOs; all pointer and flag bookkeeping lives in the owning FIFO.
//
// Ports:
//   clk      in   1   write clock, rising edge
//   i_we     in   1   write enable
//   i_waddr  in   AW  write address
//   i_wdata  in   W   write data
//   i_raddr  in   AW  read address
//   o_rdata  out  W   contents of entry i_raddr, combinational
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
   parameter  int DEPTH = 16,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset on purpose; an entry is only ever read after
   // it has been written, so clearing it would buy nothing and would turn cheap
   // storage into resettable flops.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : sync_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Every rx_done strobe
// pushes rx_data into a first-word fall-through FIFO; the consumer drains it
// over a valid/ready handshake. Also reports fill level, full/empty, a sticky
// overflow flag and a level/overflow interrupt.
//
// Ports:
//   clk           in   1     system clock, rising edge
//   resetn        in   1     synchronous active-low reset
//   rx_data       in   8     received byte, sampled when rx_done=1
//   rx_done       in   1     push strobe, one cycle per byte
//   rd_data       out  8     head-of-queue byte (8'h00 while empty)
//   rd_valid      out  1     FIFO holds at least one byte
//   rd_ready      in   1     consumer accepts; pop when rd_valid && rd_ready
//   count         out  AW+1  number of stored bytes, 0..DEPTH
//   full          out  1     count == DEPTH
//   empty         out  1     count == 0
//   overflow      out  1     sticky: a byte was dropped while full
//   overflow_clr  in   1     clears overflow (a same-cycle drop wins)
//   irq_thresh    in   AW+1  level interrupt threshold, 0 disables
//   irq           out  1     level interrupt OR overflow
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = UART_RXFIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_done,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [AW:0]            count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   overflow_clr,
   input  logic [AW:0]            irq_thresh,
   output logic                   irq
);

   localparam logic [AW:0]   C_FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_COUNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE    = AW'(1);

   // State
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   // Per-cycle decisions
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_mem_we;
   logic                   w_thresh_hit;
   logic [UART_DATA_W-1:0] w_mem_rdata;

   assign w_full  = (r_count == C_FULL_COUNT);
   assign w_empty = (r_count == '0);

   // A pop frees a slot in the same cycle, so a full FIFO can still take a
   // byte when the consumer is draining; only a push into a full FIFO with no
   // simultaneous pop is dropped.
   assign w_pop  = !w_empty && rd_ready;
   assign w_push = rx_done && (!w_full || w_pop);
   assign w_drop = rx_done && w_full && !w_pop;

   // Keep the array untouched during a reset cycle so that an rx_done
   // coinciding with reset leaves no trace.
   assign w_mem_we = w_push && resetn;

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (UART_DATA_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (rx_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and block ordering cannot matter.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         // Pointers wrap modulo DEPTH through natural AW-bit overflow.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_COUNT_ONE;
            2'b01:   r_count <= r_count - C_COUNT_ONE;
            default: r_count <= r_count;
         endcase

         // Set has priority over clear so a drop is never lost.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (overflow_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // The array is not reset, so the head is forced to zero while empty to
   // give a defined rd_data after reset.
   assign rd_data  = w_empty ? '0 : w_mem_rdata;
   assign rd_valid = !w_empty;
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;
   assign overflow = r_overflow;

   assign w_thresh_hit = (irq_thresh != '0) && (r_count >= irq_thresh);
   assign irq          = w_thresh_hit || r_overflow;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH=16): a table of single-cycle
// vectors, hand-written multi-cycle sequences for full/overflow/wrap/threshold
// /reset corners, and a randomized run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk;
   logic          resetn;
   logic [7:0]    rx_data;
   logic          rx_done;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          overflow_clr;
   logic [AW:0]   irq_thresh;
   logic          irq;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .irq_thresh   (irq_thresh),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rn;
      logic       done;
      logic [7:0] data;
      logic       rdy;
      logic       clr;
      logic [4:0] thr;
      logic [4:0] e_count;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_ovf;
      logic       e_irq;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample #1 later.
   task automatic cyc(input logic rn, input logic done, input logic [7:0] d,
                      input logic rdy, input logic clr);
      resetn       = rn;
      rx_done      = done;
      rx_data      = d;
      rd_ready     = rdy;
      overflow_clr = clr;
      @(posedge clk);
      #1;
      resetn       = 1'b1;
      rx_done      = 1'b0;
      rd_ready     = 1'b0;
      overflow_clr = 1'b0;
   endtask

   // Reference model state
   logic [7:0] q [$];
   logic       m_ovf;

   initial begin
      resetn       = 1'b0;
      rx_done      = 1'b0;
      rx_data      = 8'h00;
      rd_ready     = 1'b0;
      overflow_clr = 1'b0;
      irq_thresh   = '0;

      // ---------------- table-driven vectors ----------------
      //           rn    done  data   rdy   clr   thr    cnt   vld   data   ovf   irq
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd2, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 8'hA5, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 8'h77, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 8'h11, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         irq_thresh = vecs[i].thr;
         cyc(vecs[i].rn, vecs[i].done, vecs[i].data, vecs[i].rdy, vecs[i].clr);
         check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
         check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].e_valid);
         check($sformatf("vec%0d_empty", i), empty, !vecs[i].e_valid);
         if (vecs[i].e_valid || !vecs[i].rn)
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].e_data);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
         check($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
      end

      // ---------------- fill, overflow, full+pop, drain, wrap ----------------
      irq_thresh = '0;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", count, 16);
      check("fill_full", full, 1'b1);
      check("fill_head", rd_data, 8'h00);
      check("fill_irq_thr0", irq, 1'b0);

      cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      check("ovf_set", overflow, 1'b1);
      check("ovf_irq", irq, 1'b1);
      check("ovf_count", count, 16);

      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", overflow, 1'b0);
      check("full_thr0_irq", irq, 1'b0);

      cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
      check("ovf_set_wins", overflow, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr2", overflow, 1'b0);

      cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
      check("fullpop_count", count, 16);
      check("fullpop_ovf", overflow, 1'b0);
      check("fullpop_head", rd_data, 8'h01);

      for (int i = 1; i < 16; i++) begin
         check($sformatf("drain_%0d", i), rd_data, 8'(i));
         cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("drain_last", rd_data, 8'h55);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_empty", empty, 1'b1);

      cyc(1'b1, 1'b1, 8'h9A, 1'b0, 1'b0);
      check("wrap_data", rd_data, 8'h9A);
      check("wrap_count", count, 1);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_empty", empty, 1'b1);

      // ---------------- threshold interrupt ----------------
      irq_thresh = 5'd4;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      check("thr_3_irq", irq, 1'b0);
      cyc(1'b1, 1'b1, 8'h23, 1'b0, 1'b0);
      check("thr_4_irq", irq, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("thr_pop_irq", irq, 1'b0);

      // ---------------- reset mid-stream ----------------
      cyc(1'b1, 1'b1, 8'h24, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h25, 1'b0, 1'b0);
      check("pre_rst_count", count, 5);
      cyc(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_valid", rd_valid, 1'b0);
      check("rst_data", rd_data, 8'h00);
      check("rst_ovf", overflow, 1'b0);

      irq_thresh = '0;
      for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
      check("pre_rst_ovf", overflow, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("rst_ovf_cleared", overflow, 1'b0);
      check("rst_irq", irq, 1'b0);

      // ---------------- randomized run vs queue model ----------------
      q.delete();
      m_ovf = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic       rn, done, rdy, clr, m_pop, m_full, m_drop;
         logic [7:0] d;
         int         p_rdy;
         int         exp_irq;
         case ((c / 200) % 3)
            0:       p_rdy = 20;
            1:       p_rdy = 50;
            default: p_rdy = 85;
         endcase
         rn  = ($urandom_range(0, 199) != 0);
         done = ($urandom_range(0, 99) < 55);
         rdy = ($urandom_range(0, 99) < p_rdy);
         clr = ($urandom_range(0, 15) == 0);
         d   = 8'($urandom);
         irq_thresh = 5'($urandom_range(0, 16));

         // Model: a pop needs a stored byte; a byte is dropped only when the
         // buffer is full and nothing leaves it in the same cycle.
         if (!rn) begin
            q.delete();
            m_ovf = 1'b0;
         end else begin
            m_pop  = (q.size() > 0) && rdy;
            m_full = (q.size() == DEPTH);
            m_drop = done && m_full && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (done && !m_drop) q.push_back(d);
            if (m_drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
         end

         cyc(rn, done, d, rdy, clr);

         exp_irq = ((irq_thresh != 0) && (q.size() >= int'(irq_thresh))) || m_ovf;
         check("rnd_count", count, q.size());
         check("rnd_empty", empty, q.size() == 0);
         check("rnd_full", full, q.size() == DEPTH);
         check("rnd_valid", rd_valid, q.size() != 0);
         if (q.size() != 0) check("rnd_data", rd_data, q[0]);
         check("rnd_ovf", overflow, m_ovf);
         check("rnd_irq", irq, exp_irq);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer directly downstream of the UART receiver. Captures each received byte on the receiver's single-cycle `rx_done` strobe and holds it in a synchronous FIFO. Presents the bytes to the AXI register slave or the CPU-facing logic over a valid/ready interface. Also reports the fill level, a sticky overflow flag, and a level-threshold interrupt.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived, not overridden).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  byte from the receiver; sampled only when `rx_done`=1.
- `rx_done`  in  1  push strobe, one cycle per received byte.
- `rd_data`  out  8  head-of-queue byte (first-word fall-through).
- `rd_valid`  out  1  FIFO non-empty; `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts; a pop occurs when `rd_valid && rd_ready`.
- `count`  out  AW+1  current number of stored bytes, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `overflow_clr`  in  1  clears `overflow`.
- `irq_thresh`  in  AW+1  interrupt level; 0 disables the level interrupt.
- `irq`  out  1  interrupt request.

## Operation
- Storage: DEPTH×8 register array, write pointer `wr_ptr` [AW-1:0], read pointer `rd_ptr` [AW-1:0], and registered `count`.
- Pointers wrap modulo DEPTH through natural AW-bit overflow.
- Push: `rx_done`=1 and (not full, or a pop occurs in the same cycle). Writes `mem[wr_ptr]`=`rx_data` and increments `wr_ptr`.
- Pop: `rd_valid && rd_ready`. Increments `rd_ptr`.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged
  - neither: unchanged
- Full and pop in the same cycle: the push is accepted and no overflow is flagged.
- Empty and `rx_done` with `rd_ready`=1: no pop occurs (`rd_valid`=0). Count becomes 1.
- Full, `rx_done`, no pop: the byte is discarded, pointers and `count` are unchanged, and `overflow` is set on the next edge.
- `overflow_clr` clears `overflow`. If a new overflow event occurs in the same cycle as `overflow_clr`, set wins and `overflow` stays 1.
- `rd_data` = `mem[rd_ptr]`, combinational from registers. Its value is don't-care when empty; it is driven 8'h00 after reset.
- `irq` = ((`irq_thresh` != 0) && (`count` >= `irq_thresh`)) || `overflow`. This is combinational from registers and the `irq_thresh` input.

## Timing
- Reset (`resetn`=0 at a clock edge) sets:
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overflow`=0
  - outputs: `empty`=1, `full`=0, `rd_valid`=0, `rd_data`=8'h00, `irq`=0
  - array contents are not cleared.
- Reset mid-stream discards all stored bytes. An `rx_done` in a reset cycle is ignored.
- Push-to-visible latency is 1 cycle: after a push into an empty FIFO at edge N, `rd_valid`=1 and `rd_data` is valid after edge N.
- Pop takes effect at the edge. The next byte (or `rd_valid`=0) appears after that edge.
- Back-to-back `rx_done` strobes on consecutive cycles each push one byte.
- `count`, `full`, `empty`, and `irq` reflect state after the last edge. There is no additional pipeline stage.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W`=8 and `UART_RXFIFO_DEPTH`=16. `uart_rx` and the future `uart_tx_fifo` use the same package.
- One natural sub-module: `sync_fifo_mem`, a DEPTH×W register array with one write port and one asynchronous read port. The TX FIFO reuses it.
- Pointer, count, and flag logic live in `uart_rx_fifo`.

## Test plan
- Reset, then push 8'hA5 with `rd_ready`=0 → next cycle `rd_valid`=1, `rd_data`=8'hA5, `count`=1; raise `rd_ready` → `empty`=1 next cycle.
- Push 0x00..0x0F back-to-back with `rd_ready`=0 → `full`=1, `count`=16; drain → bytes read in order 0x00..0x0F, pointers wrap and a 17th push/pop pair returns the correct byte.
- With the FIFO full, push 8'hFF without pop → `overflow`=1, `irq`=1, `count`=16, and 8'hFF is never read; pulse `overflow_clr` → `overflow`=0.
- With the FIFO full, push 8'h55 and pop in the same cycle → `count` stays 16, `overflow`=0, and 8'h55 is read last.
- `irq_thresh`=4: push 3 bytes → `irq`=0; 4th push → `irq`=1; one pop → `irq`=0. With `irq_thresh`=0 and the FIFO full, `irq`=0.
- Assert `resetn`=0 with 5 bytes stored and `rx_done`=1 → next cycle `count`=0, `empty`=1, `overflow`=0.
